// File: rtl/spi_bridge_pkg.sv
// rtl/spi_bridge_pkg.sv - frame layout and FSM state encoding for the SPI register bridge
package spi_bridge_pkg;

  localparam int FRAME_BITS = 40;
  localparam int RW_BIT     = 39;
  localparam int ADDR_MSB   = 35;
  localparam int ADDR_LSB   = 24;
  localparam int DATA_MSB   = 23;
  localparam int DATA_LSB   = 0;

  // A read is decoded once R/nW, reserved bits and address have arrived.
  localparam int READ_DECODE_BITS = 16;
  localparam int EARLY_SHIFT      = FRAME_BITS - READ_DECODE_BITS;

  typedef enum logic [1:0] {
    WAIT_IDLE = 2'd0,
    IDLE      = 2'd1,
    SHIFT     = 2'd2,
    DONE      = 2'd3
  } state_t;

endpackage

// File: rtl/sync_edge_detect.sv
// rtl/sync_edge_detect.sv - multi-flop synchronizer with rise/fall event pulses
module sync_edge_detect #(
  parameter int SYNC_STAGES = 2
) (
  input  logic i_Clock,
  input  logic i_Reset,
  input  logic i_Async,
  output logic o_Level,
  output logic o_Rise,
  output logic o_Fall
);

  logic [SYNC_STAGES-1:0] r_Sync;
  logic                   r_Prev;

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      r_Sync <= '0;
      r_Prev <= 1'b0;
    end else begin
      r_Sync <= {r_Sync[SYNC_STAGES-2:0], i_Async};
      r_Prev <= r_Sync[SYNC_STAGES-1];
    end
  end

  assign o_Level = r_Sync[SYNC_STAGES-1];
  assign o_Rise  = o_Level & ~r_Prev;
  assign o_Fall  = ~o_Level & r_Prev;

endmodule

// File: rtl/spi_register_bridge.sv
// rtl/spi_register_bridge.sv - oversampled SPI mode-0 target decoding 40-bit frames
// into one-cycle register write/read strobes, with read data returned on MISO.
module spi_register_bridge
  import spi_bridge_pkg::*;
#(
  parameter int ADDR_WIDTH  = 12,
  parameter int DATA_WIDTH  = 24,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  i_Clock,
  input  logic                  i_Reset,
  input  logic                  i_SPI_SCK,
  input  logic                  i_SPI_CS_n,
  input  logic                  i_SPI_MOSI,
  output logic                  o_SPI_MISO,
  output logic [ADDR_WIDTH-1:0] o_RegisterNumber,
  output logic [DATA_WIDTH-1:0] o_RegisterValue,
  output logic                  o_RegisterWriteEnable,
  output logic                  o_RegisterReadEnable,
  input  logic [DATA_WIDTH-1:0] i_RegisterReadValue
);

  localparam logic [5:0] FULL_COUNT = 6'(FRAME_BITS);
  localparam logic [5:0] READ_COUNT = 6'(READ_DECODE_BITS);

  logic w_SckLevel, w_SckRise, w_SckFall;
  logic w_CsLevel, w_CsRise, w_CsFall;
  logic w_Mosi;

  logic [SYNC_STAGES-1:0] r_MosiSync;
  logic [FRAME_BITS-1:0]  r_Shift;
  logic [5:0]             r_BitCount;
  logic [DATA_WIDTH-1:0]  r_MisoShift;
  logic                   r_ReadIssued;
  logic                   r_ReadLoad;
  logic                   r_WritePending;
  state_t                 r_State;

  sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES)) u_sck_sync (
    .i_Clock (i_Clock),
    .i_Reset (i_Reset),
    .i_Async (i_SPI_SCK),
    .o_Level (w_SckLevel),
    .o_Rise  (w_SckRise),
    .o_Fall  (w_SckFall)
  );

  sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES)) u_cs_sync (
    .i_Clock (i_Clock),
    .i_Reset (i_Reset),
    .i_Async (i_SPI_CS_n),
    .o_Level (w_CsLevel),
    .o_Rise  (w_CsRise),
    .o_Fall  (w_CsFall)
  );

  // MOSI shares the SCK synchronizer depth so its level lines up with the rise event.
  always_ff @(posedge i_Clock) begin
    if (i_Reset) r_MosiSync <= '0;
    else         r_MosiSync <= {r_MosiSync[SYNC_STAGES-2:0], i_SPI_MOSI};
  end
  assign w_Mosi = r_MosiSync[SYNC_STAGES-1];

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      r_State               <= WAIT_IDLE;
      r_Shift               <= '0;
      r_BitCount            <= '0;
      r_MisoShift           <= '0;
      r_ReadIssued          <= 1'b0;
      r_ReadLoad            <= 1'b0;
      r_WritePending        <= 1'b0;
      o_SPI_MISO            <= 1'b0;
      o_RegisterNumber      <= '0;
      o_RegisterValue       <= '0;
      o_RegisterWriteEnable <= 1'b0;
      o_RegisterReadEnable  <= 1'b0;
    end else begin
      o_RegisterWriteEnable <= 1'b0;
      o_RegisterReadEnable  <= 1'b0;
      r_ReadLoad            <= o_RegisterReadEnable;
      if (r_ReadLoad) r_MisoShift <= i_RegisterReadValue;

      unique case (r_State)
        WAIT_IDLE: begin
          o_SPI_MISO <= 1'b0;
          if (w_CsLevel && !w_SckLevel) r_State <= IDLE;
        end
        IDLE: begin
          o_SPI_MISO <= 1'b0;
          if (w_CsFall) begin
            r_State        <= SHIFT;
            r_BitCount     <= '0;
            r_ReadIssued   <= 1'b0;
            r_WritePending <= 1'b0;
            r_MisoShift    <= '0;
          end
        end
        SHIFT: begin
          if (w_CsRise) begin
            r_State    <= IDLE;
            o_SPI_MISO <= 1'b0;
          end else if (r_BitCount == FULL_COUNT) begin
            r_State        <= DONE;
            r_WritePending <= ~r_Shift[RW_BIT];
          end else begin
            if (w_SckRise) begin
              r_Shift    <= {r_Shift[FRAME_BITS-2:0], w_Mosi};
              r_BitCount <= r_BitCount + 6'd1;
            end
            if (w_SckFall) begin
              o_SPI_MISO  <= r_MisoShift[DATA_WIDTH-1];
              r_MisoShift <= {r_MisoShift[DATA_WIDTH-2:0], 1'b0};
            end
            if (r_BitCount == READ_COUNT && r_Shift[RW_BIT-EARLY_SHIFT] && !r_ReadIssued) begin
              r_ReadIssued         <= 1'b1;
              o_RegisterReadEnable <= 1'b1;
              o_RegisterNumber     <= r_Shift[ADDR_MSB-EARLY_SHIFT:ADDR_LSB-EARLY_SHIFT];
            end
          end
        end
        DONE: begin
          o_SPI_MISO <= 1'b0;
          if (r_WritePending) begin
            r_WritePending        <= 1'b0;
            o_RegisterWriteEnable <= 1'b1;
            o_RegisterNumber      <= r_Shift[ADDR_MSB:ADDR_LSB];
            o_RegisterValue       <= r_Shift[DATA_MSB:DATA_LSB];
          end
          if (w_CsLevel) r_State <= IDLE;
        end
        default: r_State <= WAIT_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_register_bridge.sv
// tb/tb_spi_register_bridge.sv - directed frame table plus reset checks for spi_register_bridge
module tb_spi_register_bridge;

  localparam int SYNC = 2;
  localparam int HALF = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        sck;
  logic        cs_n;
  logic        mosi;
  logic        miso;
  logic [11:0] num;
  logic [23:0] val;
  logic        we;
  logic        re;
  logic [23:0] rd_value = 24'h0;
  logic        re_d = 1'b0;

  int cyc      = 0;
  int we_total = 0;
  int re_total = 0;
  int we_cyc   = 0;
  int n_vec    = 0;
  int n_miss   = 0;

  always #5 clk = ~clk;

  spi_register_bridge #(.ADDR_WIDTH(12), .DATA_WIDTH(24), .SYNC_STAGES(SYNC)) dut (
    .i_Clock               (clk),
    .i_Reset               (rst),
    .i_SPI_SCK             (sck),
    .i_SPI_CS_n            (cs_n),
    .i_SPI_MOSI            (mosi),
    .o_SPI_MISO            (miso),
    .o_RegisterNumber      (num),
    .o_RegisterValue       (val),
    .o_RegisterWriteEnable (we),
    .o_RegisterReadEnable  (re),
    .i_RegisterReadValue   (rd_value)
  );

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (we) begin
      we_total = we_total + 1;
      we_cyc   = cyc;
    end
    if (re) re_total = re_total + 1;
  end

  // Register file model: read data is valid only in the cycle after the strobe.
  always @(negedge clk) begin
    rd_value = re_d ? 24'h123456 : 24'h0;
    re_d     = re;
  end

  typedef struct {
    logic        rw;
    logic [11:0] addr;
    logic [23:0] data;
    int          nbits;
    int          rst_at;
    int          gap;
    int          exp_we;
    int          exp_re;
    logic [11:0] exp_num;
    logic [23:0] exp_val;
    logic [23:0] exp_miso;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec = n_vec + 1;
    if (act !== exp) begin
      n_miss = n_miss + 1;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic send_frame(input vec_t v, output logic [23:0] miso_word, output int lat_mark);
    logic [39:0] frame;
    frame     = {v.rw, 3'b000, v.addr, v.data};
    miso_word = '0;
    lat_mark  = -1;
    @(negedge clk);
    cs_n = 1'b0;
    repeat (HALF) @(negedge clk);
    for (int i = 0; i < v.nbits; i++) begin
      mosi = (i < 40) ? frame[39-i] : ~mosi;
      if (i == v.rst_at) begin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
      end
      repeat (HALF) @(negedge clk);
      if (i >= 16 && i < 40) miso_word = {miso_word[22:0], miso};
      sck = 1'b1;
      if (i == 39) lat_mark = cyc;
      repeat (HALF) @(negedge clk);
      sck = 1'b0;
    end
    repeat (HALF) @(negedge clk);
    cs_n = 1'b1;
    mosi = 1'b0;
    repeat (v.gap) @(negedge clk);
  endtask

  initial begin
    logic [23:0] miso_word;
    int          lat_mark;
    int          we0;
    int          re0;

    //          rw    addr     data        nb  rst gap we re  num      val          miso
    vecs[0] = '{1'b0, 12'h042, 24'h00ABCD, 40, -1, 8,  1, 0, 12'h042, 24'h00ABCD, 24'h0};
    vecs[1] = '{1'b1, 12'h085, 24'hFFFFFF, 40, -1, 8,  0, 1, 12'h085, 24'h00ABCD, 24'h123456};
    vecs[2] = '{1'b0, 12'h001, 24'h777777, 30, -1, 8,  0, 0, 12'h085, 24'h00ABCD, 24'h0};
    vecs[3] = '{1'b0, 12'h002, 24'h000001, 40, -1, 8,  1, 0, 12'h002, 24'h000001, 24'h0};
    vecs[4] = '{1'b0, 12'h010, 24'hFFFFFF, 48, -1, 8,  1, 0, 12'h010, 24'hFFFFFF, 24'h0};
    vecs[5] = '{1'b0, 12'h123, 24'h55AA55, 40, 20, 8,  0, 0, 12'h000, 24'h000000, 24'h0};
    vecs[6] = '{1'b0, 12'h020, 24'h0A0B0C, 40, -1, 8,  1, 0, 12'h020, 24'h0A0B0C, 24'h0};
    vecs[7] = '{1'b0, 12'h003, 24'h000005, 40, -1, 16, 1, 0, 12'h003, 24'h000005, 24'h0};
    vecs[8] = '{1'b0, 12'h004, 24'h000006, 40, -1, 16, 1, 0, 12'h004, 24'h000006, 24'h0};

    rst  = 1'b1;
    sck  = 1'b0;
    cs_n = 1'b1;
    mosi = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_we", 32'(we), 32'd0);
    check("reset_re", 32'(re), 32'd0);
    check("reset_miso", 32'(miso), 32'd0);
    check("reset_num", 32'(num), 32'd0);
    check("reset_val", 32'(val), 32'd0);
    rst = 1'b0;
    repeat (6) @(negedge clk);

    for (int k = 0; k < 9; k++) begin
      we0 = we_total;
      re0 = re_total;
      send_frame(vecs[k], miso_word, lat_mark);
      check($sformatf("v%0d_we_count", k), 32'(we_total - we0), 32'(vecs[k].exp_we));
      check($sformatf("v%0d_re_count", k), 32'(re_total - re0), 32'(vecs[k].exp_re));
      check($sformatf("v%0d_number", k), 32'(num), 32'(vecs[k].exp_num));
      check($sformatf("v%0d_value", k), 32'(val), 32'(vecs[k].exp_val));
      check($sformatf("v%0d_miso", k), 32'(miso_word), 32'(vecs[k].exp_miso));
      if (vecs[k].exp_we == 1)
        check($sformatf("v%0d_latency", k), 32'(we_cyc - lat_mark), 32'(SYNC + 3));
    end

    check("idle_miso", 32'(miso), 32'd0);
    check("idle_we", 32'(we), 32'd0);
    check("idle_re", 32'(re), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
